// File: rtl/pattern_match_engine.sv
// Pattern search over a stored string with '.', '^', '$' and '*' tokens.
// Define PME_MATCH_COUNT_EN to add match_cnt and scan every start position.

module pattern_match_engine #(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int IDX_W     = $clog2(STR_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             busy,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index
`ifdef PME_MATCH_COUNT_EN
  ,
  output logic [IDX_W:0]   match_cnt
`endif
);

  localparam int LW = IDX_W + 1;
  localparam int PW = $clog2(PAT_DEPTH + 1);
  localparam int PA = $clog2(PAT_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t state;

  logic [7:0] str_mem [STR_DEPTH];
  logic [7:0] pat_mem [PAT_DEPTH];

  logic [LW-1:0]    slen;
  logic [LW-1:0]    p;
  logic [LW-1:0]    i;
  logic [LW-1:0]    star_i;
  logic [PW-1:0]    plen;
  logic [PW-1:0]    lead;
  logic [PW-1:0]    j;
  logic [PW-1:0]    star_j;
  logic             star_v;
  logic             job_done;
  logic             found;
  logic [IDX_W-1:0] first;
`ifdef PME_MATCH_COUNT_EN
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    cnt_n;
`endif

  logic [7:0]       tok;
  logic [7:0]       ch;
  logic [7:0]       prv;
  logic             is_star;
  logic             is_bol;
  logic             is_eol;
  logic             is_any;
  logic             tok_hit;
  logic             hit;
  logic             can_bt;
  logic             fail;
  logic             last;
  logic             fin;
  logic             adv;
  logic             found_n;
  logic [IDX_W-1:0] first_n;

  logic             str_we;
  logic [IDX_W-1:0] str_wa;
  logic             pat_we;

  assign tok = pat_mem[j[PA-1:0]];
  assign ch  = str_mem[i[IDX_W-1:0]];
  assign prv = str_mem[i[IDX_W-1:0] - IDX_W'(1)];

  assign is_star = (tok == 8'h2A);
  assign is_bol  = (tok == 8'h5E);
  assign is_eol  = (tok == 8'h24);
  assign is_any  = (tok == 8'h2E);

  // Anchors are zero-width: they test the position, never consume.
  always_comb begin
    tok_hit = 1'b0;
    unique case (1'b1)
      is_star: tok_hit = 1'b1;
      is_bol:  tok_hit = (i == '0) || (prv == 8'h20);
      is_eol:  tok_hit = (i == slen) || (ch == 8'h20);
      default: tok_hit = (i < slen) && (is_any || ch == tok);
    endcase
  end

  assign hit     = (j == plen);
  assign can_bt  = star_v && (star_i < slen);
  assign fail    = !hit && !tok_hit && !can_bt;
  assign last    = (p == slen);
  assign found_n = found | hit;
  assign first_n = found ? first : p[IDX_W-1:0];

`ifdef PME_MATCH_COUNT_EN
  assign cnt_n = cnt + LW'(hit);
  assign fin   = (hit | fail) & last;
`else
  assign fin   = hit | (fail & last);
`endif
  assign adv = (hit | fail) & !fin;

  assign str_we = (state == IDLE) && isstring &&
                  (job_done || slen < LW'(STR_DEPTH));
  assign str_wa = job_done ? '0 : slen[IDX_W-1:0];
  assign pat_we = (state == IDLE) && !isstring && ispattern &&
                  (plen < PW'(PAT_DEPTH));

  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_wa] <= chardata;
    if (pat_we) pat_mem[plen[PA-1:0]] <= chardata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '1;
      slen        <= '0;
      plen        <= '0;
      lead        <= '0;
      p           <= '0;
      i           <= '0;
      j           <= '0;
      star_i      <= '0;
      star_j      <= '0;
      star_v      <= 1'b0;
      job_done    <= 1'b0;
      found       <= 1'b0;
      first       <= '0;
`ifdef PME_MATCH_COUNT_EN
      cnt         <= '0;
      match_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (isstring) begin
            if (job_done) begin
              slen     <= LW'(1);
              job_done <= 1'b0;
            end else if (slen < LW'(STR_DEPTH)) begin
              slen <= slen + LW'(1);
            end
          end else if (ispattern) begin
            if (plen < PW'(PAT_DEPTH)) begin
              plen <= plen + PW'(1);
              if (lead == plen && chardata == 8'h2A)
                lead <= lead + PW'(1);
            end
          end else if (plen != '0) begin
            state  <= SEARCH;
            busy   <= 1'b1;
            p      <= '0;
            i      <= '0;
            j      <= lead;
            star_v <= 1'b0;
            found  <= 1'b0;
            first  <= '0;
`ifdef PME_MATCH_COUNT_EN
            cnt    <= '0;
`endif
          end
        end
        SEARCH: begin
          found <= found_n;
          first <= first_n;
`ifdef PME_MATCH_COUNT_EN
          cnt   <= cnt_n;
`endif
          if (fin) begin
            state       <= DONE;
            valid       <= 1'b1;
            match       <= found_n;
            match_index <= found_n ? first_n : '1;
`ifdef PME_MATCH_COUNT_EN
            match_cnt   <= cnt_n;
`endif
          end else if (adv) begin
            p      <= p + LW'(1);
            i      <= p + LW'(1);
            j      <= lead;
            star_v <= 1'b0;
          end else if (tok_hit) begin
            if (is_star) begin
              star_v <= 1'b1;
              star_j <= j;
              star_i <= i;
              j      <= j + PW'(1);
            end else if (is_bol || is_eol) begin
              j <= j + PW'(1);
            end else begin
              i <= i + LW'(1);
              j <= j + PW'(1);
            end
          end else begin
            // Let the most recent '*' absorb one more character.
            star_i <= star_i + LW'(1);
            i      <= star_i + LW'(1);
            j      <= star_j + PW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          valid    <= 1'b0;
          plen     <= '0;
          lead     <= '0;
          job_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_match_engine.sv
// Directed and randomized checks of pattern_match_engine
// against an NFA-style reference model.

module tb_pattern_match_engine;

  localparam int SD    = 32;
  localparam int PD    = 8;
  localparam int IW    = 5;
  localparam int LIMIT = (SD + 1) * (SD + 1) * (PD + 1) + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    chardata = 8'h00;
  logic          isstring = 1'b0;
  logic          ispattern = 1'b0;
  logic          busy;
  logic          valid;
  logic          match;
  logic [IW-1:0] match_index;
`ifdef PME_MATCH_COUNT_EN
  logic [IW:0]   match_cnt;
`endif

  int checks = 0;
  int errors = 0;

  byte unsigned mstr[$];
  byte unsigned mpat[$];
  bit           mdone = 1'b0;

  byte unsigned sa[4] = '{8'h61, 8'h62, 8'h20, 8'h63};
  byte unsigned pa[8] = '{8'h61, 8'h62, 8'h20, 8'h63,
                          8'h2E, 8'h2A, 8'h5E, 8'h24};

  always #5 clk = ~clk;

  pattern_match_engine #(
    .STR_DEPTH(SD),
    .PAT_DEPTH(PD),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chardata(chardata),
    .isstring(isstring),
    .ispattern(ispattern),
    .busy(busy),
    .valid(valid),
    .match(match),
    .match_index(match_index)
`ifdef PME_MATCH_COUNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put_s(input byte unsigned c);
    @(negedge clk);
    chardata = c;
    isstring = 1'b1;
    ispattern = 1'b0;
    if (mdone) begin
      mstr.delete();
      mdone = 1'b0;
    end
    if (mstr.size() < SD) mstr.push_back(c);
  endtask

  task automatic put_p(input byte unsigned c);
    @(negedge clk);
    chardata = c;
    isstring = 1'b0;
    ispattern = 1'b1;
    if (mpat.size() < PD) mpat.push_back(c);
  endtask

  task automatic put_b(input byte unsigned c);
    @(negedge clk);
    chardata = c;
    isstring = 1'b1;
    ispattern = 1'b1;
    if (mdone) begin
      mstr.delete();
      mdone = 1'b0;
    end
    if (mstr.size() < SD) mstr.push_back(c);
  endtask

  task automatic put_str(input string s);
    for (int k = 0; k < s.len(); k++) put_s(s[k]);
  endtask

  task automatic put_pat(input string s);
    for (int k = 0; k < s.len(); k++) put_p(s[k]);
  endtask

  // Set of reachable string positions, advanced token by token.
  function automatic void model(output bit m, output int idx,
                                output int cnt);
    int           lead;
    int           len;
    bit           r[SD+1];
    bit           nr[SD+1];
    byte unsigned t;
    bit           any;
    lead = 0;
    len = mstr.size();
    while (lead < mpat.size() && mpat[lead] == 8'h2A) lead++;
    m = 1'b0;
    idx = (1 << IW) - 1;
    cnt = 0;
    for (int p = 0; p <= len; p++) begin
      for (int k = 0; k <= SD; k++) r[k] = (k == p);
      for (int jj = lead; jj < mpat.size(); jj++) begin
        t = mpat[jj];
        for (int k = 0; k <= SD; k++) nr[k] = 1'b0;
        for (int k = 0; k <= len; k++) begin
          if (r[k]) begin
            if (t == 8'h2A) begin
              for (int q = k; q <= len; q++) nr[q] = 1'b1;
            end else if (t == 8'h5E) begin
              if (k == 0 || mstr[k-1] == 8'h20) nr[k] = 1'b1;
            end else if (t == 8'h24) begin
              if (k == len || mstr[k] == 8'h20) nr[k] = 1'b1;
            end else if (t == 8'h2E) begin
              if (k < len) nr[k+1] = 1'b1;
            end else begin
              if (k < len && mstr[k] == t) nr[k+1] = 1'b1;
            end
          end
        end
        r = nr;
      end
      any = 1'b0;
      for (int k = 0; k <= len; k++) any |= r[k];
      if (any) begin
        cnt++;
        if (!m) begin
          m = 1'b1;
          idx = p;
        end
      end
    end
  endfunction

  task automatic run_job(input string tag, input bit em,
                         input int ei, input int ec);
    int n;
    @(negedge clk);
    isstring = 1'b0;
    ispattern = 1'b0;
    @(negedge clk);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 32'(valid), 32'd1);
    if (valid) begin
      check({tag, ".match"}, 32'(match), 32'(em));
      check({tag, ".index"}, 32'(match_index), 32'(ei));
`ifdef PME_MATCH_COUNT_EN
      check({tag, ".cnt"}, 32'(match_cnt), 32'(ec));
`endif
    end
    @(negedge clk);
    check({tag, ".pulse"}, 32'(valid), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    mpat.delete();
    mdone = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.match", 32'(match), 32'd0);
    check("rst.index", 32'(match_index), 32'd31);
`ifdef PME_MATCH_COUNT_EN
    check("rst.cnt", 32'(match_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    put_pat("^$");
    run_job("empty_anch", 1'b1, 0, 1);
    put_pat("a");
    run_job("empty_lit", 1'b0, 31, 0);

    put_str("hello world");
    put_pat("wor");
    run_job("hello", 1'b1, 6, 1);

    put_str("abc abd");
    put_pat("^abd$");
    run_job("anchor", 1'b1, 4, 1);
    put_pat("xy");
    run_job("retained", 1'b0, 31, 0);

    put_str("aXbYc");
    put_pat("a*b*c");
    run_job("stars", 1'b1, 0, 1);
    put_pat("a*d");
    run_job("star_miss", 1'b0, 31, 0);

    put_b(8'h71);
    put_str("rs");
    put_pat("r");
    run_job("collide", 1'b1, 1, 1);

    put_str("zabcdefghz");
    put_pat("abcdefghXY");
    run_job("pat_sat", 1'b1, 1, 1);
    put_pat("**gh");
    run_job("lead_star", 1'b1, 7, 1);

    put_str("aaaa");
    put_pat("aa");
    run_job("count", 1'b1, 0, 3);

    for (int k = 0; k < 40; k++) put_s(8'(8'h41 + k % 26));
    put_pat(".$");
    run_job("str_sat", 1'b1, 31, 1);

    put_str("hello world");
    put_pat("d");
    @(negedge clk);
    isstring = 1'b0;
    ispattern = 1'b0;
    @(negedge clk);
    check("mid.busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid.busy0", 32'(busy), 32'd0);
    check("mid.valid0", 32'(valid), 32'd0);
    check("mid.match0", 32'(match), 32'd0);
    check("mid.index0", 32'(match_index), 32'd31);
`ifdef PME_MATCH_COUNT_EN
    check("mid.cnt0", 32'(match_cnt), 32'd0);
`endif
    mstr.delete();
    mpat.delete();
    mdone = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    put_str("hello world");
    put_pat("wor");
    run_job("post_rst", 1'b1, 6, 1);

    for (int r = 0; r < 40; r++) begin
      int sl;
      int pl;
      bit em;
      int ei;
      int ec;
      if ($urandom_range(0, 3) != 0) begin
        sl = $urandom_range(1, 10);
        for (int k = 0; k < sl; k++) put_s(sa[$urandom_range(0, 3)]);
      end
      pl = $urandom_range(1, 5);
      for (int k = 0; k < pl; k++) put_p(pa[$urandom_range(0, 7)]);
      model(em, ei, ec);
      run_job($sformatf("rnd%0d", r), em, ei, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
